shade_light: RTL

Lambertian shading stage that sits directly downstream of the nearest-hit selector. It captures one hit per transaction: hit distance, reversed-face flag, normal axis and four signed direction-to-light vectors. It evaluates one light per cycle with a shift-based N·L/|L| approximation, applies distance fog and an ambient floor, and presents an 8-bit shade value on a valid/ready output.

---
 rtl/shade_light.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/shade_light.sv
// shade_light: Lambertian shading of one captured hit against four lights,
// one light per cycle, followed by distance fog, ambient floor and a
// valid/ready output stage.
module shade_light #(
   parameter int unsigned AMBIENT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hit_valid,
   input  logic [9:0]        hit_dist,
   input  logic              hit_rev,
   input  logic [1:0]        hit_normal_dir,
   input  logic signed [9:0] dir_to_light_0_x,
   input  logic signed [9:0] dir_to_light_0_y,
   input  logic signed [9:0] dir_to_light_0_z,
   input  logic signed [9:0] dir_to_light_1_x,
   input  logic signed [9:0] dir_to_light_1_y,
   input  logic signed [9:0] dir_to_light_1_z,
   input  logic signed [9:0] dir_to_light_2_x,
   input  logic signed [9:0] dir_to_light_2_y,
   input  logic signed [9:0] dir_to_light_2_z,
   input  logic signed [9:0] dir_to_light_3_x,
   input  logic signed [9:0] dir_to_light_3_y,
   input  logic signed [9:0] dir_to_light_3_z,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        shade,
   output logic [9:0]        shade_dist,
   output logic [7:0]        drop_cnt
);

   localparam int unsigned DW = 10;   // distance / vector component width
   localparam int unsigned MW = 11;   // widened signed n and unsigned |L|_1
   localparam int unsigned AW = 9;    // accumulator width
   localparam int unsigned PW = 17;   // n << 6 before normalisation
   localparam int unsigned SW = 10;   // ambient + fogged sum before clamp
   localparam int unsigned NL = 4;    // number of lights

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_L0   = 3'd1,
      S_L1   = 3'd2,
      S_L2   = 3'd3,
      S_L3   = 3'd4,
      S_OUT  = 3'd5
   } state_t;

   state_t state_q, state_d;

   logic [DW-1:0]        dist_q;
   logic                 rev_q;
   logic [1:0]           ndir_q;
   logic signed [DW-1:0] lx_q [NL];
   logic signed [DW-1:0] ly_q [NL];
   logic signed [DW-1:0] lz_q [NL];
   logic [AW-1:0]        acc_q;

   logic                 accept_c;
   logic                 drop_c;
   logic [1:0]           li_c;
   logic signed [DW-1:0] cx_c, cy_c, cz_c;
   logic signed [MW-1:0] c_c, n_c;
   logic [MW-1:0]        m_c;
   logic [3:0]           s_c;
   logic [AW-1:0]        contrib_c;
   logic [AW-1:0]        acc_sum_c;
   logic [AW-1:0]        fog_c;
   logic [SW-1:0]        lit_c;
   logic [7:0]           shade_c;

   // Absolute value widened by one bit so that |-512| = 512 is representable.
   function automatic logic [MW-1:0] abs_w(input logic signed [DW-1:0] v);
      logic signed [MW-1:0] w;
      w = MW'(v);
      return w[MW-1] ? $unsigned(-w) : $unsigned(w);
   endfunction

   // Handshake qualifiers: accept only in IDLE, everything else is a drop.
   always_comb begin
      accept_c = hit_valid && (state_q == S_IDLE);
      drop_c   = hit_valid && (state_q != S_IDLE);
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state: four light cycles, then hold in OUT until consumed.
   always_comb begin
      state_d = state_q;
      li_c    = 2'd0;
      case (state_q)
         S_IDLE: if (hit_valid) state_d = S_L0;
         S_L0: begin li_c = 2'd0; state_d = S_L1; end
         S_L1: begin li_c = 2'd1; state_d = S_L2; end
         S_L2: begin li_c = 2'd2; state_d = S_L3; end
         S_L3: begin li_c = 2'd3; state_d = S_OUT; end
         S_OUT: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Per-light N.L/|L| approximation: (n << 6) >> msb(|dx|+|dy|+|dz|).
   always_comb begin
      cx_c = lx_q[li_c];
      cy_c = ly_q[li_c];
      cz_c = lz_q[li_c];
      c_c  = '0;
      case (ndir_q)
         2'd0:    c_c = MW'(cx_c);
         2'd1:    c_c = MW'(cy_c);
         2'd2:    c_c = MW'(cz_c);
         default: c_c = '0;
      endcase
      n_c = rev_q ? -c_c : c_c;
      m_c = abs_w(cx_c) + abs_w(cy_c) + abs_w(cz_c);
      s_c = 4'd0;
      for (int i = 0; i < int'(MW); i++) begin
         if (m_c[i]) s_c = 4'(i);
      end
      if (n_c[MW-1] || (n_c == '0) || (m_c == '0) || (ndir_q == 2'd3))
         contrib_c = '0;
      else
         contrib_c = AW'((PW'($unsigned(n_c)) << 6) >> s_c);
      acc_sum_c = acc_q + contrib_c;
   end

   // Fog by distance bucket, ambient floor, clamp to 8 bits.
   always_comb begin
      fog_c   = acc_sum_c >> dist_q[DW-1:DW-2];
      lit_c   = SW'(AMBIENT) + SW'(fog_c);
      shade_c = (lit_c > SW'(255)) ? 8'hFF : lit_c[7:0];
   end

   // Hit capture and light accumulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dist_q <= '0;
         rev_q  <= 1'b0;
         ndir_q <= '0;
         acc_q  <= '0;
         for (int k = 0; k < int'(NL); k++) begin
            lx_q[k] <= '0;
            ly_q[k] <= '0;
            lz_q[k] <= '0;
         end
      end else if (accept_c) begin
         dist_q  <= hit_dist;
         rev_q   <= hit_rev;
         ndir_q  <= hit_normal_dir;
         acc_q   <= '0;
         lx_q[0] <= dir_to_light_0_x;
         ly_q[0] <= dir_to_light_0_y;
         lz_q[0] <= dir_to_light_0_z;
         lx_q[1] <= dir_to_light_1_x;
         ly_q[1] <= dir_to_light_1_y;
         lz_q[1] <= dir_to_light_1_z;
         lx_q[2] <= dir_to_light_2_x;
         ly_q[2] <= dir_to_light_2_y;
         lz_q[2] <= dir_to_light_2_z;
         lx_q[3] <= dir_to_light_3_x;
         ly_q[3] <= dir_to_light_3_y;
         lz_q[3] <= dir_to_light_3_z;
      end else if ((state_q == S_L0) || (state_q == S_L1) ||
                   (state_q == S_L2) || (state_q == S_L3)) begin
         acc_q <= acc_sum_c;
      end
   end

   // Registered output stage; held stable under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         shade      <= '0;
         shade_dist <= '0;
         in_ready   <= 1'b1;
      end else begin
         in_ready <= (state_d == S_IDLE);
         if (state_q == S_L3) begin
            out_valid  <= 1'b1;
            shade      <= shade_c;
            shade_dist <= dist_q;
         end else if ((state_q == S_OUT) && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Saturating count of hits offered while busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       drop_cnt <= '0;
      else if (drop_c && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
   end

endmodule
